idct4_pipe: RTL and testbench

- Parametrised 4-point 1-D inverse DCT datapath; next generation of the fixed 16-in/24-out IDCT stage.
- Adds configurable widths, a rounding shift, saturation with flag, per-sample bypass mode, and a valid/ready handshake with full backpressure.
- Three-stage pipeline, one 4-sample vector per cycle; drops into the row/column IDCT chain between the input buffer and the next transform stage.

---
 rtl/idct4_pipe.sv | 177 +++++++++++++++++
 tb/tb_idct4_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct4_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idct4_pipe                                                      |
// | Purpose  : 4-point 1-D inverse DCT, three-stage pipeline with rounding     |
// |            shift, output saturation, per-vector bypass and a valid/ready   |
// |            handshake with full backpressure.                               |
// | Ports    : clk, reset (async, active-low)                                  |
// |            in_valid/in_ready/in_mode, d_in_1..4  : input vector x0..x3     |
// |            out_valid/out_ready, d_out_1..4       : output vector y0..y3    |
// |            out_sat : at least one lane of the output vector was clipped    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module idct4_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [IN_W-1:0]  d_in_1,
  input  logic signed [IN_W-1:0]  d_in_2,
  input  logic signed [IN_W-1:0]  d_in_3,
  input  logic signed [IN_W-1:0]  d_in_4,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] d_out_1,
  output logic signed [OUT_W-1:0] d_out_2,
  output logic signed [OUT_W-1:0] d_out_3,
  output logic signed [OUT_W-1:0] d_out_4,
  output logic                    out_sat
);

  // Butterfly precision, recombine/round precision (room for the bypass
  // pre-shift plus the rounding add), and the clip-compare width.
  localparam int BW = IN_W + 9;
  localparam int YW = IN_W + SHIFT + 11;
  localparam int CW = ((YW > OUT_W) ? YW : OUT_W) + 1;

  localparam logic signed [BW-1:0] c_k64  = BW'(64);
  localparam logic signed [BW-1:0] c_k83  = BW'(83);
  localparam logic signed [BW-1:0] c_k36  = BW'(36);
  // Half an LSB of the shifted result; zero when SHIFT = 0.
  localparam logic signed [YW-1:0] c_half = YW'((2 ** SHIFT) / 2);
  localparam logic signed [CW-1:0] c_max  = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] c_min  = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Global advance: the whole pipe moves unless a valid output is blocked.
  logic w_en;
  logic r_out_valid;
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // ---------------------------------------------------------------- stage 1
  logic signed [IN_W-1:0] w_x  [4];
  logic signed [BW-1:0]   w_xs [4];
  logic signed [BW-1:0]   w_e0, w_e1, w_o0, w_o1;

  assign w_x[0] = d_in_1;
  assign w_x[1] = d_in_2;
  assign w_x[2] = d_in_3;
  assign w_x[3] = d_in_4;

  for (genvar k = 0; k < 4; k++) begin : g_sext
    assign w_xs[k] = {{9{w_x[k][IN_W-1]}}, w_x[k]};
  end

  assign w_e0 = c_k64 * w_xs[0] + c_k64 * w_xs[2];
  assign w_e1 = c_k64 * w_xs[0] - c_k64 * w_xs[2];
  assign w_o0 = c_k83 * w_xs[1] + c_k36 * w_xs[3];
  assign w_o1 = c_k36 * w_xs[1] - c_k83 * w_xs[3];

  logic                   r_s1_valid;
  logic                   r_s1_mode;
  logic signed [BW-1:0]   r_e0, r_e1, r_o0, r_o1;
  logic signed [IN_W-1:0] r_s1_x [4];   // raw samples kept for bypass

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_e0       <= '0;
      r_e1       <= '0;
      r_o0       <= '0;
      r_o1       <= '0;
      for (int k = 0; k < 4; k++) r_s1_x[k] <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= in_mode;
      r_e0       <= w_e0;
      r_e1       <= w_e1;
      r_o0       <= w_o0;
      r_o1       <= w_o1;
      for (int k = 0; k < 4; k++) r_s1_x[k] <= w_x[k];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [YW-1:0] w_e0x, w_e1x, w_o0x, w_o1x;
  logic signed [YW-1:0] w_yc  [4];
  logic signed [YW-1:0] w_byp [4];
  logic signed [YW-1:0] w_y   [4];

  assign w_e0x = {{(YW-BW){r_e0[BW-1]}}, r_e0};
  assign w_e1x = {{(YW-BW){r_e1[BW-1]}}, r_e1};
  assign w_o0x = {{(YW-BW){r_o0[BW-1]}}, r_o0};
  assign w_o1x = {{(YW-BW){r_o1[BW-1]}}, r_o1};

  assign w_yc[0] = w_e0x + w_o0x;
  assign w_yc[1] = w_e1x + w_o1x;
  assign w_yc[2] = w_e1x - w_o1x;
  assign w_yc[3] = w_e0x - w_o0x;

  // Bypass pre-scales by 2^SHIFT so the rounding stage returns x unchanged.
  for (genvar k = 0; k < 4; k++) begin : g_recomb
    assign w_byp[k] = {{(YW-IN_W){r_s1_x[k][IN_W-1]}}, r_s1_x[k]} <<< SHIFT;
    assign w_y[k]   = r_s1_mode ? w_byp[k] : w_yc[k];
  end

  logic                 r_s2_valid;
  logic signed [YW-1:0] r_y [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      for (int k = 0; k < 4; k++) r_y[k] <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      for (int k = 0; k < 4; k++) r_y[k] <= w_y[k];
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [YW-1:0]    w_sum [4];
  logic signed [YW-1:0]    w_rnd [4];
  logic signed [CW-1:0]    w_rx  [4];
  logic signed [OUT_W-1:0] w_q   [4];
  logic [3:0]              w_hi;
  logic [3:0]              w_lo;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_sum[k] = r_y[k] + c_half;
    assign w_rnd[k] = w_sum[k] >>> SHIFT;   // arithmetic: rounds toward -inf
    assign w_rx[k]  = {{(CW-YW){w_rnd[k][YW-1]}}, w_rnd[k]};
    assign w_hi[k]  = (w_rx[k] > c_max);
    assign w_lo[k]  = (w_rx[k] < c_min);
    assign w_q[k]   = w_hi[k] ? c_max[OUT_W-1:0] :
                      w_lo[k] ? c_min[OUT_W-1:0] : w_rx[k][OUT_W-1:0];
  end

  logic signed [OUT_W-1:0] r_dout [4];
  logic                    r_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      for (int k = 0; k < 4; k++) r_dout[k] <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      // Bubbles never report saturation.
      r_sat       <= r_s2_valid && (|(w_hi | w_lo));
      for (int k = 0; k < 4; k++) r_dout[k] <= w_q[k];
    end
  end

  assign out_valid = r_out_valid;
  assign out_sat   = r_sat;
  assign d_out_1   = r_dout[0];
  assign d_out_2   = r_dout[1];
  assign d_out_3   = r_dout[2];
  assign d_out_4   = r_dout[3];

endmodule
`default_nettype wire

// File: tb/tb_idct4_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_idct4_pipe                                                   |
// | Purpose  : Directed self-checking bench for idct4_pipe. Three instances:   |
// |            defaults (16/24/0), SHIFT=7, and OUT_W=16 for saturation.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_idct4_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Instance A: default parameters
  logic               a_iv, a_ir, a_md, a_ov, a_or, a_sat;
  logic signed [15:0] a_x [4];
  logic signed [23:0] a_y [4];
  // Instance B: SHIFT = 7
  logic               b_iv, b_ir, b_md, b_ov, b_or, b_sat;
  logic signed [15:0] b_x [4];
  logic signed [23:0] b_y [4];
  // Instance C: OUT_W = 16
  logic               c_iv, c_ir, c_md, c_ov, c_or, c_sat;
  logic signed [15:0] c_x [4];
  logic signed [15:0] c_y [4];

  idct4_pipe u_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_md),
    .d_in_1(a_x[0]), .d_in_2(a_x[1]), .d_in_3(a_x[2]), .d_in_4(a_x[3]),
    .out_valid(a_ov), .out_ready(a_or),
    .d_out_1(a_y[0]), .d_out_2(a_y[1]), .d_out_3(a_y[2]), .d_out_4(a_y[3]),
    .out_sat(a_sat)
  );

  idct4_pipe #(.IN_W(16), .OUT_W(24), .SHIFT(7)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_md),
    .d_in_1(b_x[0]), .d_in_2(b_x[1]), .d_in_3(b_x[2]), .d_in_4(b_x[3]),
    .out_valid(b_ov), .out_ready(b_or),
    .d_out_1(b_y[0]), .d_out_2(b_y[1]), .d_out_3(b_y[2]), .d_out_4(b_y[3]),
    .out_sat(b_sat)
  );

  idct4_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .in_mode(c_md),
    .d_in_1(c_x[0]), .d_in_2(c_x[1]), .d_in_3(c_x[2]), .d_in_4(c_x[3]),
    .out_valid(c_ov), .out_ready(c_or),
    .d_out_1(c_y[0]), .d_out_2(c_y[1]), .d_out_3(c_y[2]), .d_out_4(c_y[3]),
    .out_sat(c_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic m, input int x0, input int x1, input int x2, input int x3);
    a_iv = v; a_md = m;
    a_x[0] = 16'(x0); a_x[1] = 16'(x1); a_x[2] = 16'(x2); a_x[3] = 16'(x3);
  endtask

  task automatic b_drive(input logic v, input logic m, input int x0, input int x1, input int x2, input int x3);
    b_iv = v; b_md = m;
    b_x[0] = 16'(x0); b_x[1] = 16'(x1); b_x[2] = 16'(x2); b_x[3] = 16'(x3);
  endtask

  task automatic c_drive(input logic v, input logic m, input int x0, input int x1, input int x2, input int x3);
    c_iv = v; c_md = m;
    c_x[0] = 16'(x0); c_x[1] = 16'(x1); c_x[2] = 16'(x2); c_x[3] = 16'(x3);
  endtask

  // Reset asserted from time 0: every output of every instance is cleared.
  task automatic test_reset();
    #12;
    checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0 || c_ov !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got a=%b b=%b c=%b expected 0", a_ov, b_ov, c_ov); end
    checks++; if (a_sat !== 1'b0 || b_sat !== 1'b0 || c_sat !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got a=%b b=%b c=%b expected 0", a_sat, b_sat, c_sat); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_y[k] !== 24'sd0 || c_y[k] !== 16'sd0) begin
        errors++; $display("FAIL reset_data lane%0d: got a=%0d c=%0d expected 0", k, a_y[k], c_y[k]); end
    end
    checks++; if (a_ir !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", a_ir); end
    #10;
    reset = 1'b1;
    tick();
  endtask

  // Two IDCT vectors back-to-back; exact 3-cycle latency and in_ready high.
  task automatic test_idct();
    int vx [2][4];
    int ex [2][4];
    vx = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}};
    ex = '{'{64, 64, 64, 64}, '{83, 36, -36, -83}};
    for (int c = 0; c < 6; c++) begin
      if (c < 2) a_drive(1'b1, 1'b0, vx[c][0], vx[c][1], vx[c][2], vx[c][3]);
      else       a_drive(1'b0, 1'b0, 0, 0, 0, 0);
      checks++; if (a_ir !== 1'b1) begin
        errors++; $display("FAIL idct_ready c%0d: got %b expected 1", c, a_ir); end
      if (c == 2 || c == 5) begin
        checks++; if (a_ov !== 1'b0) begin
          errors++; $display("FAIL idct_latency c%0d: out_valid got %b expected 0", c, a_ov); end
      end
      if (c == 3 || c == 4) begin
        checks++; if (a_ov !== 1'b1 || a_sat !== 1'b0) begin
          errors++; $display("FAIL idct_flags v%0d: valid=%b sat=%b expected 1/0", c-3, a_ov, a_sat); end
        for (int k = 0; k < 4; k++) begin
          checks++; if (a_y[k] !== ex[c-3][k]) begin
            errors++; $display("FAIL idct_v%0d y%0d: got %0d expected %0d", c-3, k, a_y[k], ex[c-3][k]); end
        end
      end
      tick();
    end
  endtask

  // Bypass vector followed by an IDCT vector: each uses its own mode.
  task automatic test_bypass();
    int vx [2][4];
    int ex [2][4];
    logic vm [2];
    vx = '{'{-5, 32767, -32768, 7}, '{0, 0, 1, 0}};
    ex = '{'{-5, 32767, -32768, 7}, '{64, -64, -64, 64}};
    vm = '{1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      if (c < 2) a_drive(1'b1, vm[c], vx[c][0], vx[c][1], vx[c][2], vx[c][3]);
      else       a_drive(1'b0, 1'b0, 0, 0, 0, 0);
      if (c >= 3) begin
        checks++; if (a_ov !== 1'b1 || a_sat !== 1'b0) begin
          errors++; $display("FAIL bypass_flags v%0d: valid=%b sat=%b expected 1/0", c-3, a_ov, a_sat); end
        for (int k = 0; k < 4; k++) begin
          checks++; if (a_y[k] !== ex[c-3][k]) begin
            errors++; $display("FAIL bypass_v%0d y%0d: got %0d expected %0d", c-3, k, a_y[k], ex[c-3][k]); end
        end
      end
      tick();
    end
  endtask

  // SHIFT=7 rounding, including a negative floor case and a bypass vector.
  task automatic test_shift7();
    int vx [3][4];
    int ex [3][4];
    logic vm [3];
    vx = '{'{1, 1, 0, 0}, '{-1, -1, 0, 0}, '{-3, 100, -32768, 32767}};
    ex = '{'{1, 1, 0, 0}, '{-1, -1, 0, 0}, '{-3, 100, -32768, 32767}};
    vm = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      if (c < 3) b_drive(1'b1, vm[c], vx[c][0], vx[c][1], vx[c][2], vx[c][3]);
      else       b_drive(1'b0, 1'b0, 0, 0, 0, 0);
      if (c >= 3 && c < 6) begin
        checks++; if (b_ov !== 1'b1 || b_sat !== 1'b0) begin
          errors++; $display("FAIL shift7_flags v%0d: valid=%b sat=%b expected 1/0", c-3, b_ov, b_sat); end
        for (int k = 0; k < 4; k++) begin
          checks++; if (b_y[k] !== ex[c-3][k]) begin
            errors++; $display("FAIL shift7_v%0d y%0d: got %0d expected %0d", c-3, k, b_y[k], ex[c-3][k]); end
        end
      end
      tick();
    end
  endtask

  // OUT_W=16: positive clip, clean vector, negative clip.
  task automatic test_saturate();
    int vx [3][4];
    int ex [3][4];
    logic es [3];
    vx = '{'{32767, 0, 32767, 0}, '{1, 0, 0, 0}, '{-32768, 0, -32768, 0}};
    ex = '{'{32767, 0, 0, 32767}, '{64, 64, 64, 64}, '{-32768, 0, 0, -32768}};
    es = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      if (c < 3) c_drive(1'b1, 1'b0, vx[c][0], vx[c][1], vx[c][2], vx[c][3]);
      else       c_drive(1'b0, 1'b0, 0, 0, 0, 0);
      if (c >= 3 && c < 6) begin
        checks++; if (c_ov !== 1'b1 || c_sat !== es[c-3]) begin
          errors++; $display("FAIL sat_flags v%0d: valid=%b sat=%b expected 1/%b", c-3, c_ov, c_sat, es[c-3]); end
        for (int k = 0; k < 4; k++) begin
          checks++; if (c_y[k] !== ex[c-3][k]) begin
            errors++; $display("FAIL sat_v%0d y%0d: got %0d expected %0d", c-3, k, c_y[k], ex[c-3][k]); end
        end
      end
      tick();
    end
  endtask

  // Six vectors, out_ready low on cycles 4..8; in-order delivery, held output.
  task automatic test_backpressure();
    int vx [6][4];
    int vy [6][4];
    logic vm [6];
    int snd, rcv, cyc;
    vx = '{'{1, 0, 0, 0}, '{10, -1, 1, 0}, '{0, 2, 0, 0}, '{-7, 300, -300, 9}, '{0, 0, 0, 1}, '{1, 2, 3, 4}};
    vy = '{'{64, 64, 64, 64}, '{10, -1, 1, 0}, '{166, 72, -72, -166}, '{-7, 300, -300, 9}, '{36, -83, 83, -36}, '{1, 2, 3, 4}};
    vm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    snd = 0; rcv = 0; cyc = 0;
    while (rcv < 6 && cyc < 40) begin
      cyc++;
      a_or = !(cyc >= 4 && cyc <= 8);
      if (snd < 6) a_drive(1'b1, vm[snd], vx[snd][0], vx[snd][1], vx[snd][2], vx[snd][3]);
      else         a_drive(1'b0, 1'b0, 0, 0, 0, 0);
      #1;
      if (a_ov === 1'b1) begin
        checks++;
        if (rcv >= 6) begin
          errors++; $display("FAIL bp_extra cyc%0d: got vector %0d expected none", cyc, rcv);
        end else begin
          for (int k = 0; k < 4; k++) begin
            checks++; if (a_y[k] !== vy[rcv][k]) begin
              errors++; $display("FAIL bp_v%0d y%0d cyc%0d: got %0d expected %0d", rcv, k, cyc, a_y[k], vy[rcv][k]); end
          end
        end
        if (a_or == 1'b0) begin
          if (a_ir !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready cyc%0d: got %b expected 0", cyc, a_ir); end
        end else begin
          rcv++;
        end
      end
      if (a_iv && a_ir) snd++;
      tick();
    end
    checks++; if (rcv != 6) begin
      errors++; $display("FAIL bp_count: got %0d vectors expected 6", rcv); end
    a_or = 1'b1;
    a_drive(1'b0, 1'b0, 0, 0, 0, 0);
    #1;
    checks++; if (a_ov !== 1'b0) begin
      errors++; $display("FAIL bp_duplicate: out_valid got %b expected 0", a_ov); end
    tick();
  endtask

  // Asynchronous reset with vectors in flight, then a clean restart.
  task automatic test_reset_midstream();
    int ex [4];
    ex = '{180, -415, 415, -180};
    a_or = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a_drive(1'b1, 1'b0, c + 1, 0, 0, 0);
      tick();
    end
    a_drive(1'b0, 1'b0, 0, 0, 0, 0);
    checks++; if (a_ov !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid: got %b expected 1", a_ov); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (a_ov !== 1'b0 || a_sat !== 1'b0) begin
      errors++; $display("FAIL rst_async_flags: valid=%b sat=%b expected 0/0", a_ov, a_sat); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_y[k] !== 24'sd0) begin
        errors++; $display("FAIL rst_async_y%0d: got %0d expected 0", k, a_y[k]); end
    end
    tick();
    #4;
    reset = 1'b1;
    a_drive(1'b1, 1'b0, 0, 0, 0, 5);
    tick();
    a_drive(1'b0, 1'b0, 0, 0, 0, 0);
    for (int c = 1; c < 3; c++) begin
      checks++; if (a_ov !== 1'b0) begin
        errors++; $display("FAIL rst_stale c%0d: out_valid got %b expected 0", c, a_ov); end
      tick();
    end
    checks++; if (a_ov !== 1'b1) begin
      errors++; $display("FAIL rst_restart_valid: got %b expected 1", a_ov); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_y[k] !== ex[k]) begin
        errors++; $display("FAIL rst_restart_y%0d: got %0d expected %0d", k, a_y[k], ex[k]); end
    end
    tick();
    checks++; if (a_ov !== 1'b0) begin
      errors++; $display("FAIL rst_after: out_valid got %b expected 0", a_ov); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    reset  = 1'b0;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
    a_drive(1'b0, 1'b0, 0, 0, 0, 0);
    b_drive(1'b0, 1'b0, 0, 0, 0, 0);
    c_drive(1'b0, 1'b0, 0, 0, 0, 0);

    test_reset();
    test_idct();
    test_bypass();
    test_shift7();
    test_saturate();
    test_backpressure();
    test_reset_midstream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
